i2s_rx: RTL
===========

I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 24, sample word width per channel; matches opl3_pkg DAC_OUTPUT_WIDTH.
REQ-002 Parameter SLOT_BITS, default 32, SCLK periods per channel half-frame (64-bit frame).
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer depth for i2s_sclk/i2s_ws/i2s_sd (min 2).
REQ-004 clk  input  1  system clock; one clock domain for all logic.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i2s_sclk  input  1  external bit clock, asynchronous to clk.
REQ-007 i2s_ws  input  1  word select; 0 = left, 1 = right.
REQ-008 i2s_sd  input  1  serial data, MSB first, changes on SCLK falling edge.
REQ-009 sample_valid  output  1  one-clk pulse: new stereo pair on left_channel/right_channel.
REQ-010 left_channel  output  DATA_WIDTH  last complete left word.
REQ-011 right_channel  output  DATA_WIDTH  last complete right word.
REQ-012 frame_error  output  1  one-clk pulse on half-frame length violation (see Configuration).

Function
REQ-013 Each of i2s_sclk, i2s_ws, i2s_sd SHALL pass through SYNC_STAGES flops before use.
REQ-014 A bit strobe SHALL fire for exactly one clk on each synchronized SCLK 0->1 transition; ws and sd sampled on that cycle.
REQ-015 SCLK high and low phases SHALL each be >= 2 clk periods; behaviour below that is undefined.
REQ-016 Strobe with sampled ws != previously sampled ws = WS edge: bit counter cleared to 0, current channel := new ws; sd on that strobe (previous word's last slot bit) is ignored.
REQ-017 Following strobes: bit counter increments, saturates at 63; strobes 1..DATA_WIDTH shift sd into shift register, MSB first.
REQ-018 Strobes beyond DATA_WIDTH within a slot SHALL be ignored (padding bits).
REQ-019 On the DATA_WIDTH-th data strobe, the word SHALL be committed: left word to an internal hold register; right word triggers output update.
REQ-020 Output update: left_channel := held left word, right_channel := committed right word, sample_valid = 1, all in the same cycle.
REQ-021 Latency: sample_valid high exactly SYNC_STAGES+2 clk cycles after the i2s_sclk pin rising edge carrying the right-channel LSB.
REQ-022 Lock flag: set when a left word commits; sample_valid SHALL be suppressed for a right word without a committed left word in the same frame.
REQ-023 WS edge before DATA_WIDTH data bits received: partial word discarded, no output update, lock flag cleared.
REQ-024 left_channel/right_channel SHALL hold their value between sample_valid pulses.
REQ-025 Simultaneous WS edge and commit impossible by construction; WS edge always takes priority over shifting.

Reset
REQ-026 reset high at a clk edge SHALL clear: synchronizers, shift register, bit counter to 0, lock flag, hold register, left_channel = 0, right_channel = 0, sample_valid = 0, frame_error = 0.
REQ-027 After reset, reception SHALL resume at the first WS edge; data before it discarded.
REQ-028 Reset mid-frame SHALL drop the in-flight pair; no sample_valid for it.

Configuration
REQ-029 Macro I2S_RX_FRAME_CHECK_EN defined: count strobes between consecutive WS edges; on a WS edge where count != SLOT_BITS and lock flag set, frame_error pulses one clk; first WS edge after reset never flags.
REQ-030 Macro undefined: frame_error SHALL be tied 0, no check logic; all other behaviour identical.

Verification
REQ-031 Drive frame L=0x123456, R=0xABCDEF, 64-bit I2S, SCLK = clk/4 -> one sample_valid, left_channel=0x123456, right_channel=0xABCDEF, latency per REQ-021.
REQ-032 Ten consecutive frames, L=n, R=~n -> ten pulses in order, outputs stable between pulses.
REQ-033 Start stream mid-right-slot after reset -> no sample_valid until first full left+right pair.
REQ-034 WS toggles after 10 bits of left word -> no update, next full pair accepted.
REQ-035 With I2S_RX_FRAME_CHECK_EN, one 30-bit right half-frame -> frame_error one pulse at the following WS edge; without macro -> frame_error stays 0.
REQ-036 Assert reset during bit 12 of right word -> outputs 0, no sample_valid; next complete frame decoded correctly.

Source files
------------

// File: rtl/i2s_rx.sv
// i2s_rx: I2S serial audio receiver (stereo, MSB first, 64-bit frames by default).
// SCLK/WS/SD are resynchronised into clk and decoded by oversampling; a stereo
// pair is presented on left_channel/right_channel with a one-clk sample_valid.
// Optional build macro I2S_RX_FRAME_CHECK_EN enables half-frame length checking
// on frame_error; without it frame_error is tied low.
module i2s_rx #(
  parameter int DATA_WIDTH  = 24,
  parameter int SLOT_BITS   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2s_sclk,
  input  logic                  i2s_ws,
  input  logic                  i2s_sd,
  output logic                  sample_valid,
  output logic [DATA_WIDTH-1:0] left_channel,
  output logic [DATA_WIDTH-1:0] right_channel,
  output logic                  frame_error
);

  localparam logic [5:0] LAST_DATA = 6'(DATA_WIDTH);

  logic [SYNC_STAGES-1:0] sclk_sync, ws_sync, sd_sync;
  logic                   sclk_s, ws_s, sd_s;

  logic                   sclk_d;
  logic                   strobe_r, ws_r, sd_r;

  logic                   have_ws;   // a ws value has been sampled since reset
  logic                   synced;    // at least one WS edge seen since reset
  logic                   ws_prev;
  logic                   chan;      // 0 = left slot, 1 = right slot
  logic                   lock;      // left word committed for the current frame
  logic [5:0]             bit_cnt;
  logic [DATA_WIDTH-1:0]  shift_reg;
  logic [DATA_WIDTH-1:0]  hold_left;

  logic                   ws_edge;
  logic [5:0]             cnt_next;
  logic                   data_bit;
  logic                   commit;
  logic [DATA_WIDTH-1:0]  word;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ws_s   = ws_sync[SYNC_STAGES-1];
  assign sd_s   = sd_sync[SYNC_STAGES-1];

  // Multi-flop synchronisers for the three asynchronous I2S pins
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      ws_sync   <= '0;
      sd_sync   <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i2s_sclk};
      ws_sync   <= {ws_sync[SYNC_STAGES-2:0], i2s_ws};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], i2s_sd};
    end
  end

  // Registered one-clk bit strobe on SCLK rising edge, with ws/sd captured alongside
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_d   <= 1'b0;
      strobe_r <= 1'b0;
      ws_r     <= 1'b0;
      sd_r     <= 1'b0;
    end else begin
      sclk_d   <= sclk_s;
      strobe_r <= sclk_s & ~sclk_d;
      ws_r     <= ws_s;
      sd_r     <= sd_s;
    end
  end

  // The first strobe after reset only records ws; it cannot itself be an edge.
  assign ws_edge  = strobe_r & have_ws & (ws_r != ws_prev);
  assign cnt_next = (bit_cnt == 6'd63) ? bit_cnt : bit_cnt + 6'd1;
  assign data_bit = strobe_r & synced & ~ws_edge & (cnt_next <= LAST_DATA);
  assign commit   = data_bit & (cnt_next == LAST_DATA);
  assign word     = {shift_reg[DATA_WIDTH-2:0], sd_r};

  // Slot tracking, data shifting, word commit and output update
  always_ff @(posedge clk) begin
    if (reset) begin
      have_ws       <= 1'b0;
      synced        <= 1'b0;
      ws_prev       <= 1'b0;
      chan          <= 1'b0;
      lock          <= 1'b0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      hold_left     <= '0;
      left_channel  <= '0;
      right_channel <= '0;
      sample_valid  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (strobe_r) begin
        have_ws <= 1'b1;
        ws_prev <= ws_r;
      end
      if (ws_edge) begin
        synced  <= 1'b1;
        bit_cnt <= '0;
        chan    <= ws_r;
        // Lock survives only a left->right edge that follows a complete left word.
        lock    <= ws_r & lock & (bit_cnt >= LAST_DATA);
      end else if (strobe_r && synced) begin
        bit_cnt <= cnt_next;
        if (data_bit) begin
          shift_reg <= word;
        end
        if (commit) begin
          if (!chan) begin
            hold_left <= word;
            lock      <= 1'b1;
          end else if (lock) begin
            left_channel  <= hold_left;
            right_channel <= word;
            sample_valid  <= 1'b1;
          end
        end
      end
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  localparam logic [5:0] SLOT_LAST = 6'(SLOT_BITS - 1);

  // Flag a WS edge whose preceding half-frame had the wrong number of strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_error <= 1'b0;
    end else begin
      frame_error <= ws_edge & lock & (bit_cnt != SLOT_LAST);
    end
  end
`else
  assign frame_error = 1'b0;
`endif

endmodule
